// File: rtl/bus_slave_port_pkg.sv
// Shared definitions for the bit-serial bus slave endpoint.
package bus_slave_port_pkg;

    // Transfer direction, sampled with the first address bit.
    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // Endpoint FSM encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_WRITE = 3'd3,
        ST_RREQ  = 3'd4,
        ST_RWAIT = 3'd5,
        ST_RDATA = 3'd6
    } state_e;

    // Bit counter width: must index the longer of the address and data fields.
    function automatic int unsigned cnt_width(input int unsigned aw, input int unsigned dw);
        int unsigned m;
        m = (aw > dw) ? aw : dw;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/bus_slave_port.sv
// Slave-side endpoint of the bit-serial bus: deserialises address and write
// data, strobes a single-port synchronous memory, serialises read data back.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready=1, waiting for the first address bit (mode latched)
// ST_ADDR  | shifting in remaining address bits, LSB first
// ST_WDATA | shifting in write data bits, LSB first
// ST_WRITE | mem_wen high for this single cycle
// ST_RREQ  | mem_ren high for this single cycle
// ST_RWAIT | memory returns data; captured into the tx shift register
// ST_RDATA | svalid high, one read bit per cycle, LSB first
module bus_slave_port
    import bus_slave_port_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wdata,
    input  logic                  mode,
    input  logic                  mvalid,
    output logic                  rdata,
    output logic                  svalid,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned CW = cnt_width(ADDR_WIDTH, DATA_WIDTH);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_sr_q, addr_sr_d;
    logic [DATA_WIDTH-1:0]  data_sr_q, data_sr_d;
    logic [DATA_WIDTH-1:0]  tx_sr_q, tx_sr_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic                   rdata_q, rdata_d;
    logic                   svalid_q, svalid_d;
    logic                   mem_wen_q, mem_ren_q, ready_q;

    // Incoming bits enter at the MSB so that after a full field the first
    // (LSB) bit has arrived at position 0.
    logic [ADDR_WIDTH-1:0]  addr_first, addr_shift;
    logic [DATA_WIDTH-1:0]  data_shift;

    assign addr_first = ADDR_WIDTH'(wdata) << (ADDR_WIDTH - 1);
    assign addr_shift = (addr_sr_q >> 1) | addr_first;
    assign data_shift = (data_sr_q >> 1) | (DATA_WIDTH'(wdata) << (DATA_WIDTH - 1));

    // Next-state and datapath decode; gaps (mvalid=0) leave everything held.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        addr_sr_d   = addr_sr_q;
        data_sr_d   = data_sr_q;
        tx_sr_d     = tx_sr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = 1'b0;
        svalid_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mvalid) begin
                    mode_d    = mode;
                    addr_sr_d = addr_first;
                    cnt_d     = CW'(1);
                    if (ADDR_WIDTH == 1) begin
                        mem_addr_d = addr_first;
                        cnt_d      = '0;
                        state_d    = (mode == MODE_WRITE) ? ST_WDATA : ST_RREQ;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (mvalid) begin
                    addr_sr_d = addr_shift;
                    cnt_d     = cnt_q + CW'(1);
                    if (cnt_q == ADDR_LAST) begin
                        mem_addr_d = addr_shift;
                        cnt_d      = '0;
                        state_d    = (mode_q == MODE_WRITE) ? ST_WDATA : ST_RREQ;
                    end
                end
            end
            ST_WDATA: begin
                if (mvalid) begin
                    data_sr_d = data_shift;
                    cnt_d     = cnt_q + CW'(1);
                    if (cnt_q == DATA_LAST) begin
                        mem_wdata_d = data_shift;
                        cnt_d       = '0;
                        state_d     = ST_WRITE;
                    end
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_RREQ:  state_d = ST_RWAIT;
            ST_RWAIT: begin
                // Bit 0 goes straight to the output register; the rest wait in tx.
                rdata_d  = mem_rdata[0];
                tx_sr_d  = mem_rdata >> 1;
                svalid_d = 1'b1;
                cnt_d    = '0;
                state_d  = ST_RDATA;
            end
            ST_RDATA: begin
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    rdata_d  = tx_sr_q[0];
                    tx_sr_d  = tx_sr_q >> 1;
                    svalid_d = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; strobes decode the upcoming state so they
    // are glitch-free and track exactly one WRITE/RREQ cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_READ;
            cnt_q       <= '0;
            addr_sr_q   <= '0;
            data_sr_q   <= '0;
            tx_sr_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= 1'b0;
            svalid_q    <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_ren_q   <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            addr_sr_q   <= addr_sr_d;
            data_sr_q   <= data_sr_d;
            tx_sr_q     <= tx_sr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            svalid_q    <= svalid_d;
            mem_wen_q   <= (state_d == ST_WRITE);
            mem_ren_q   <= (state_d == ST_RREQ);
            ready_q     <= (state_d == ST_IDLE);
        end
    end

    assign rdata     = rdata_q;
    assign svalid    = svalid_q;
    assign ready     = ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wen   = mem_wen_q;
    assign mem_ren   = mem_ren_q;

endmodule

// File: tb/tb_bus_slave_port.sv
// Bench for bus_slave_port: serial bus driver, behavioural memory beside the
// DUT, and an array model of expected memory contents.
module tb_bus_slave_port;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          wdata = 1'b0;
    logic          mode = 1'b0;
    logic          mvalid = 1'b0;
    logic          rdata, svalid, ready, mem_wen, mem_ren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    bus_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wdata     (wdata),
        .mode      (mode),
        .mvalid    (mvalid),
        .rdata     (rdata),
        .svalid    (svalid),
        .ready     (ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory instance stand-in: synchronous, read data valid the cycle after mem_ren.
    logic [DW-1:0] ram     [1 << AW];
    logic [DW-1:0] ref_mem [1 << AW];

    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    int wen_cnt = 0, ren_cnt = 0, sv_cnt = 0, overlap_cnt = 0;
    int exp_wen = 0, exp_ren = 0, exp_sv = 0;
    int last_addr_edge = 0, last_data_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_wen) wen_cnt++;
        if (mem_ren) ren_cnt++;
        if (svalid) sv_cnt++;
        if (mem_wen && mem_ren) overlap_cnt++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mvalid = 1'b0;
            wdata  = 1'($urandom_range(1));
            mode   = 1'($urandom_range(1));
        end
    endtask

    // Serialise one transaction; gap_mask bit i inserts idle cycles after bit i
    // (bits 0..AW-1 address, AW.. data). glitch holds mode inverted after bit 0.
    task automatic send(input logic md, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [AW+DW-1:0] gap_mask, input int gap_pct, input bit glitch);
        int nb;
        nb = (md == 1'b1) ? AW + DW : AW;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            if (i == 0) chk_eq("ready_idle", ready, 1);
            if (i == 1) chk_eq("ready_busy", ready, 0);
            mvalid = 1'b1;
            if (i < AW) wdata = a[i];
            else        wdata = d[i-AW];
            if (i == 0)      mode = md;
            else if (glitch) mode = ~md;
            else             mode = 1'($urandom_range(1));
            if (i == AW-1) last_addr_edge = cyc + 1;
            if (i == nb-1) last_data_edge = cyc + 1;
            if (i < nb-1 && (gap_mask[i] || ($urandom_range(99) < gap_pct))) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    mvalid = 1'b0;
                    wdata  = 1'($urandom_range(1));
                    mode   = 1'($urandom_range(1));
                end
            end
        end
    endtask

    // Wait for the write strobe; stray mvalid during WRITE must be ignored.
    task automatic finish_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clk);
            if (mem_wen) begin
                seen = 1'b1;
                chk_eq({tag, "_wen_lat"}, cyc - last_data_edge, 0);
                chk_eq({tag, "_addr"}, mem_addr, a);
                chk_eq({tag, "_wdata"}, mem_wdata, d);
                chk_eq({tag, "_ren_low"}, mem_ren, 0);
                chk_eq({tag, "_ready_low"}, ready, 0);
            end
            mvalid = 1'($urandom_range(1));
            wdata  = 1'($urandom_range(1));
            mode   = 1'($urandom_range(1));
        end
        chk_eq({tag, "_wen_seen"}, seen, 1);
        ref_mem[a] = d;
        exp_wen++;
    endtask

    // Collect the serial read reply and compare with the model contents.
    task automatic finish_read(input logic [AW-1:0] a, input string tag);
        bit seen;
        logic [DW-1:0] got;
        int first, nvalid;
        seen = 1'b0; got = '0; first = 0; nvalid = 0;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clk);
            if (svalid) begin
                seen = 1'b1; first = cyc; got[0] = rdata; nvalid = 1;
            end
            mvalid = 1'($urandom_range(1));
            wdata  = 1'($urandom_range(1));
            mode   = 1'($urandom_range(1));
        end
        chk_eq({tag, "_sv_seen"}, seen, 1);
        if (seen) begin
            for (int b = 1; b < DW; b++) begin
                @(negedge clk);
                if (svalid) nvalid++;
                got[b] = rdata;
                mvalid = 1'($urandom_range(1));
                wdata  = 1'($urandom_range(1));
            end
            // First bit lies in the third clock period after the last-address edge.
            chk_eq({tag, "_rd_lat"}, first - last_addr_edge, 2);
            chk_eq({tag, "_sv_len"}, nvalid, DW);
            chk_eq({tag, "_rdata"}, got, ref_mem[a]);
        end
        exp_ren++;
        exp_sv += DW;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] v;
        bit   is_wr;

        for (int i = 0; i < (1 << AW); i++) begin
            v = DW'($urandom);
            ram[i] = v;
            ref_mem[i] = v;
        end
        ram[12'h123] = 8'h3C;
        ref_mem[12'h123] = 8'h3C;

        #2 rstn = 1'b0;
        #1;
        chk_eq("rst_ready", ready, 1);
        chk_eq("rst_svalid", svalid, 0);
        chk_eq("rst_rdata", rdata, 0);
        chk_eq("rst_wen", mem_wen, 0);
        chk_eq("rst_ren", mem_ren, 0);
        chk_eq("rst_addr", mem_addr, 0);
        chk_eq("rst_wdata", mem_wdata, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        drive_idle(2);

        // Read of preloaded 0x3C at 0x123, then a write of 0xA5 there.
        send(1'b0, 12'h123, 8'h00, '0, 0, 1'b0);
        finish_read(12'h123, "rd123");
        drive_idle(2);
        send(1'b1, 12'h123, 8'hA5, '0, 0, 1'b0);
        finish_write(12'h123, 8'hA5, "wr123");
        drive_idle(2);

        // Gapped write to the all-ones address, then read it back.
        send(1'b1, 12'hFFF, 8'h5A, 20'((1 << 3) | (1 << 11) | (1 << (AW + 5))), 0, 1'b0);
        finish_write(12'hFFF, 8'h5A, "wr_gap");
        drive_idle(1);
        send(1'b0, 12'hFFF, 8'h00, '0, 0, 1'b0);
        finish_read(12'hFFF, "rd_fff");
        drive_idle(2);

        // Reset while the read is waiting for memory data.
        send(1'b0, 12'h123, 8'h00, '0, 0, 1'b0);
        @(negedge clk);
        chk_eq("rr_ren", mem_ren, 1);
        mvalid = 1'b0;
        exp_ren++;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_eq("rr_ready", ready, 1);
        chk_eq("rr_svalid", svalid, 0);
        chk_eq("rr_rdata", rdata, 0);
        chk_eq("rr_wen", mem_wen, 0);
        chk_eq("rr_ren_low", mem_ren, 0);
        chk_eq("rr_addr", mem_addr, 0);
        chk_eq("rr_wdata", mem_wdata, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        drive_idle(4);
        chk_eq("rr_no_sv", sv_cnt, exp_sv);
        chk_eq("rr_no_ren", ren_cnt, exp_ren);
        d = DW'($urandom);
        send(1'b1, 12'h000, d, '0, 0, 1'b0);
        finish_write(12'h000, d, "wr_000");
        drive_idle(1);
        send(1'b0, 12'h000, 8'h00, '0, 0, 1'b0);
        finish_read(12'h000, "rd_000");
        drive_idle(2);

        // Back-to-back write then read: ready high for a single cycle between.
        send(1'b1, 12'h001, 8'h11, '0, 0, 1'b0);
        finish_write(12'h001, 8'h11, "b2b_wr");
        send(1'b0, 12'h001, 8'h00, '0, 0, 1'b0);
        finish_read(12'h001, "b2b_rd");
        drive_idle(2);

        // Mode flipped to write after the first bit of a read.
        send(1'b0, 12'h2C7, 8'h00, '0, 0, 1'b1);
        finish_read(12'h2C7, "glitch_rd");
        drive_idle(1);
        chk_eq("glitch_no_wen", wen_cnt, exp_wen);

        // Random traffic with gaps, random mode noise and back-to-back issue.
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(9))
                0:       a = '0;
                1:       a = '1;
                default: a = AW'($urandom);
            endcase
            d = DW'($urandom);
            is_wr = 1'($urandom_range(1));
            send(is_wr, a, d, '0, 25, 1'b0);
            if (is_wr) finish_write(a, d, $sformatf("rnd%0d_wr", t));
            else       finish_read(a, $sformatf("rnd%0d_rd", t));
            drive_idle($urandom_range(0, 2));
        end

        drive_idle(4);
        chk_eq("tot_wen", wen_cnt, exp_wen);
        chk_eq("tot_ren", ren_cnt, exp_ren);
        chk_eq("tot_sv", sv_cnt, exp_sv);
        chk_eq("no_overlap", overlap_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
